// File: rtl/xadc_pkg.sv
// xadc_pkg
// Shared definitions for the XADC voltage sampler: DRP sequencer state
// encoding, default DRP channel address, default drdy timeout and the
// width of the ADC code carried in the DRP read data.
package xadc_pkg;

    localparam int ADC_WIDTH = 12;

    localparam logic [6:0] DEFAULT_CHANNEL_ADDR = 7'h03;

    localparam int DEFAULT_TIMEOUT = 63;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_RDY = 2'd2,
        ACCUM    = 2'd3
    } state_t;

endpackage

// File: rtl/boxcar_avg.sv
// boxcar_avg
// Accumulates 2^AVG_LOG2 ADC codes and publishes their truncated mean.
// The accumulator is ADC_WIDTH+AVG_LOG2 bits, which holds a full batch of
// maximum codes without wrapping.
//
// Ports
//   clock          rising-edge system clock
//   resetn         synchronous active-low reset
//   sample_valid   one-cycle strobe: add 'sample' to the running batch
//   sample         ADC code to accumulate
//   voltage        last published average, held between updates
//   voltage_valid  one-cycle pulse in the cycle 'voltage' takes a new value
module boxcar_avg
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 sample_valid,
    input  logic [ADC_WIDTH-1:0] sample,
    output logic [ADC_WIDTH-1:0] voltage,
    output logic                 voltage_valid
);

    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    // A zero-width counter is not legal, so AVG_LOG2=0 still gets one bit
    // that simply stays at zero (every sample completes a batch).
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]     accumulator;
    logic [ACC_W-1:0]     sum;
    logic [ADC_WIDTH-1:0] average;
    logic [CNT_W-1:0]     sample_count;

    assign sum     = accumulator + ACC_W'(sample);
    assign average = ADC_WIDTH'(sum >> AVG_LOG2);

    // The last sample of a batch goes straight into the average rather than
    // through the accumulator, so the result appears one cycle after the strobe.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            accumulator   <= '0;
            sample_count  <= '0;
            voltage       <= '0;
            voltage_valid <= 1'b0;
        end else begin
            voltage_valid <= 1'b0;
            if (sample_valid) begin
                if (sample_count == CNT_LAST) begin
                    voltage       <= average;
                    voltage_valid <= 1'b1;
                    accumulator   <= '0;
                    sample_count  <= '0;
                end else begin
                    accumulator  <= sum;
                    sample_count <= sample_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/xadc_voltage_sampler.sv
// xadc_voltage_sampler
// Reads the sensed-voltage channel of the XADC over DRP once per
// end-of-conversion and feeds the codes into a boxcar averager whose output
// drives the regulator stage.
//
// Ports
//   clock          rising-edge system clock
//   resetn         synchronous active-low reset
//   eoc            XADC end-of-conversion pulse
//   den            DRP enable, one-cycle pulse per read
//   daddr          DRP address (always CHANNEL_ADDR)
//   dwe            DRP write enable, tied low (read-only use)
//   do_data        DRP read data, ADC code in [15:4]
//   drdy           DRP data-ready strobe
//   voltage        averaged ADC code, held between updates
//   voltage_valid  one-cycle pulse when voltage is updated
//   timeout_err    sticky: a DRP read was never acknowledged
//   overrun        sticky: eoc arrived while a read was still in flight
module xadc_voltage_sampler #(
    parameter logic [6:0] CHANNEL_ADDR = xadc_pkg::DEFAULT_CHANNEL_ADDR,
    parameter int          AVG_LOG2     = 4,
    parameter int          TIMEOUT      = xadc_pkg::DEFAULT_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           eoc,
    output logic                           den,
    output logic [6:0]                     daddr,
    output logic                           dwe,
    input  logic [15:0]                    do_data,
    input  logic                           drdy,
    output logic [xadc_pkg::ADC_WIDTH-1:0] voltage,
    output logic                           voltage_valid,
    output logic                           timeout_err,
    output logic                           overrun
);

    import xadc_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t               state;
    state_t               next_state;
    logic [TW-1:0]        tmo_cnt;
    logic [ADC_WIDTH-1:0] sample_reg;
    logic                 sample_load;
    logic                 sample_valid;
    logic                 tmo_hit;
    logic                 unused_lsbs;

    assign daddr       = CHANNEL_ADDR;
    assign dwe         = 1'b0;
    assign unused_lsbs = ^do_data[3:0];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT_RDY lasts at most TIMEOUT cycles; in its cycle k (k = 0..)
    // tmo_cnt holds k, so the final cycle without drdy gives up the read.
    always_comb begin
        next_state   = state;
        den          = 1'b0;
        sample_load  = 1'b0;
        sample_valid = 1'b0;
        tmo_hit      = 1'b0;
        case (state)
            IDLE: begin
                if (eoc) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                den        = 1'b1;
                next_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (drdy) begin
                    sample_load = 1'b1;
                    next_state  = ACCUM;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    next_state = IDLE;
                end
            end
            ACCUM: begin
                sample_valid = 1'b1;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // An eoc seen outside IDLE is dropped, not queued; only the flag records it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tmo_cnt     <= '0;
            sample_reg  <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (state == REQUEST) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_RDY && !drdy) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (sample_load) begin
                sample_reg <= do_data[15:4];
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
            if (eoc && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    boxcar_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_boxcar_avg (
        .clock        (clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample_reg),
        .voltage      (voltage),
        .voltage_valid(voltage_valid)
    );

endmodule

// File: tb/tb_xadc_voltage_sampler.sv
// tb_xadc_voltage_sampler
// Directed bench for xadc_voltage_sampler. The stimulus tasks record what
// the outputs must do (den cycles, averaged results, flag onset cycles) as
// plain arithmetic over the codes read; a negedge process compares every
// output against that record each cycle, and literal values pin each batch.
module tb_xadc_voltage_sampler;

    localparam logic [6:0] CH_ADDR = 7'h03;
    localparam int AVG_LOG2 = 4;
    localparam int AVG_N    = 1 << AVG_LOG2;
    localparam int TIMEOUT  = 63;

    typedef struct {
        int         cycle;
        logic [11:0] value;
    } vv_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        eoc;
    logic        den;
    logic [6:0]  daddr;
    logic        dwe;
    logic [15:0] do_data;
    logic        drdy;
    logic [11:0] voltage;
    logic        voltage_valid;
    logic        timeout_err;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 1'b0;

    // reference model state
    int          den_q[$];
    vv_t         vv_q[$];
    int          batch[$];
    logic [11:0] model_voltage;
    int          terr_from;
    int          ovr_from;
    logic        exp_den;
    logic        exp_vv;

    xadc_voltage_sampler #(
        .CHANNEL_ADDR(CH_ADDR),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .eoc          (eoc),
        .den          (den),
        .daddr        (daddr),
        .dwe          (dwe),
        .do_data      (do_data),
        .drdy         (drdy),
        .voltage      (voltage),
        .voltage_valid(voltage_valid),
        .timeout_err  (timeout_err),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle's inputs, then move to just after the next rising edge.
    task automatic applyStimulus(input logic e, input logic d, input logic [15:0] data);
        eoc     = e;
        drdy    = d;
        do_data = data;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        den_q.delete();
        vv_q.delete();
        batch.delete();
        model_voltage = 12'h000;
        terr_from     = -1;
        ovr_from      = -1;
    endtask

    task automatic apply_reset();
        checking = 1'b0;
        resetn   = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        resetn = 1'b1;
        clear_model();
        checking = 1'b1;
    endtask

    task automatic note_overrun(input int from_cycle);
        if (ovr_from < 0) ovr_from = from_cycle;
    endtask

    // Add one code to the running batch; a full batch yields its truncated mean.
    task automatic model_sample(input logic [11:0] code, input int valid_cycle);
        int  sum;
        vv_t ev;
        batch.push_back(int'(code));
        if (batch.size() == AVG_N) begin
            sum = 0;
            foreach (batch[i]) sum += batch[i];
            ev.cycle = valid_cycle;
            ev.value = 12'(sum / AVG_N);
            vv_q.push_back(ev);
            batch.delete();
        end
    endtask

    // One eoc-triggered read; drdy arrives 'delay' cycles into WAIT_RDY.
    // extra_eoc >= 0 raises eoc again in that WAIT_RDY cycle.
    task automatic do_read(input logic [15:0] data, input int delay, input int extra_eoc);
        int  n;
        bit  e_now;
        den_q.push_back(cyc + 1);
        applyStimulus(1'b1, 1'b0, 16'($urandom));
        applyStimulus(1'b0, 1'b0, 16'($urandom));
        n = cyc + delay;
        for (int k = 0; k <= delay; k++) begin
            e_now = (k == extra_eoc);
            if (e_now) note_overrun(cyc + 1);
            if (k == delay) applyStimulus(e_now, 1'b1, data);
            else            applyStimulus(e_now, 1'b0, 16'($urandom));
        end
        model_sample(data[15:4], n + 2);
        applyStimulus(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic do_timeout();
        den_q.push_back(cyc + 1);
        if (terr_from < 0) terr_from = cyc + 1 + TIMEOUT + 1;
        applyStimulus(1'b1, 1'b0, 16'h0000);
        repeat (TIMEOUT + 1) applyStimulus(1'b0, 1'b0, 16'($urandom));
    endtask

    always @(negedge clock) begin
        if (checking) begin
            exp_den = 1'b0;
            if (den_q.size() > 0 && den_q[0] == cyc) begin
                exp_den = 1'b1;
                void'(den_q.pop_front());
            end
            exp_vv = 1'b0;
            if (vv_q.size() > 0 && vv_q[0].cycle == cyc) begin
                exp_vv        = 1'b1;
                model_voltage = vv_q[0].value;
                void'(vv_q.pop_front());
            end
            checkOutput("den", 16'(den), 16'(exp_den));
            if (den) checkOutput("daddr", 16'(daddr), 16'(CH_ADDR));
            checkOutput("dwe", 16'(dwe), 16'h0000);
            checkOutput("voltage_valid", 16'(voltage_valid), 16'(exp_vv));
            checkOutput("voltage", 16'(voltage), 16'(model_voltage));
            checkOutput("timeout_err", 16'(timeout_err), 16'(terr_from >= 0 && cyc >= terr_from));
            checkOutput("overrun", 16'(overrun), 16'(ovr_from >= 0 && cyc >= ovr_from));
        end
    end

    initial begin
        resetn  = 1'b0;
        eoc     = 1'b0;
        drdy    = 1'b0;
        do_data = 16'h0000;
        clear_model();
        @(posedge clock);
        #1;
        apply_reset();
        checkOutput("reset_voltage", 16'(voltage), 16'h0000);
        checkOutput("reset_flags", 16'({timeout_err, overrun, voltage_valid, den}), 16'h0000);

        for (int i = 0; i < 16; i++) do_read(16'h8000, i % 3, -1);
        checkOutput("avg_8000", 16'(voltage), 16'h0800);

        for (int i = 0; i < 8; i++) do_read(16'h0010, 0, -1);
        for (int i = 0; i < 8; i++) do_read(16'h0020, 1, -1);
        checkOutput("avg_1_2_trunc", 16'(voltage), 16'h0001);

        for (int i = 0; i < 16; i++) do_read(16'hFFF0, i % 2, -1);
        checkOutput("avg_fff0", 16'(voltage), 16'h0FFF);

        do_timeout();
        checkOutput("timeout_flag", 16'(timeout_err), 16'h0001);
        applyStimulus(1'b0, 1'b1, 16'hFFF0);
        for (int i = 0; i < 16; i++) do_read(16'h4000, 2, -1);
        checkOutput("avg_after_timeout", 16'(voltage), 16'h0400);

        for (int i = 0; i < 7; i++) do_read(16'hFFF0, 0, -1);
        den_q.push_back(cyc + 1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        apply_reset();
        applyStimulus(1'b0, 1'b1, 16'hFFF0);
        for (int i = 0; i < 16; i++) do_read(16'h1000, i % 4, -1);
        checkOutput("avg_after_reset", 16'(voltage), 16'h0100);
        checkOutput("flags_after_reset", 16'({timeout_err, overrun}), 16'h0000);

        do_read(16'h2000, 3, 1);
        checkOutput("overrun_flag", 16'(overrun), 16'h0001);
        do_read(16'h2000, 2, 2);
        for (int i = 0; i < 14; i++) do_read(16'h2000, 0, -1);
        checkOutput("avg_with_overrun", 16'(voltage), 16'h0200);

        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("pending_events", 16'(den_q.size() + vv_q.size()), 16'h0000);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
